branch_resolve_unit: RTL and testbench

- Closes the loop on the fetch-stage BTB predictor.
- Records each fetch-time prediction (pc, taken, target) in an in-order in-flight queue.
- Compares the oldest entry against the actual branch outcome resolved in MEM.
- Produces the BTB write port (update_en/update_pc/update_target), a pipeline redirect/flush, and prediction statistics.

---
 rtl/branch_resolve_unit_if.sv | 39 +++
 rtl/branch_resolve_unit.sv | 109 ++++++++++
 tb/tb_branch_resolve_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Fetch/resolve handshake and BTB-update bundle between the pipeline and the
// branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             fetch_ready;

  logic             resolve_valid;
  logic [31:0]      resolve_pc;
  logic             actual_taken;
  logic [31:0]      actual_target;

  logic             update_en;
  logic [31:0]      update_pc;
  logic [31:0]      update_target;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             desync_err;

  modport master (
    output fetch_valid, fetch_pc, pred_taken, pred_target,
    output resolve_valid, resolve_pc, actual_taken, actual_target,
    input  fetch_ready, update_en, update_pc, update_target,
    input  redirect, redirect_pc, branch_count, mispredict_count, desync_err
  );

  modport slave (
    input  fetch_valid, fetch_pc, pred_taken, pred_target,
    input  resolve_valid, resolve_pc, actual_taken, actual_target,
    output fetch_ready, update_en, update_pc, update_target,
    output redirect, redirect_pc, branch_count, mispredict_count, desync_err
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Tracks in-flight BTB predictions in fetch order and checks the oldest one
// against the MEM-stage outcome, producing BTB writes, redirects and stats.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW:0]      CNT_ONE  = (AW + 1)'(1);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  logic [31:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic             update_en_reg, redirect_reg, desync_reg;
  logic [31:0]      update_pc_reg, update_target_reg, redirect_pc_reg;
  logic [CNT_W-1:0] branch_count_reg, mispredict_count_reg;

  logic        full, empty, pop, push, mispredict, need_update, desync_next;
  logic [31:0] head_pc, head_target;
  logic        head_taken;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // Head is read combinationally so the compare happens in the resolve cycle.
  assign head_pc     = pc_mem[rd_ptr_reg];
  assign head_taken  = taken_mem[rd_ptr_reg];
  assign head_target = target_mem[rd_ptr_reg];

  assign pop = bus.resolve_valid && !empty;
  assign mispredict = pop && ((head_taken != bus.actual_taken) ||
                      (head_taken && bus.actual_taken && (head_target != bus.actual_target)));
  assign need_update = pop && bus.actual_taken &&
                       (!head_taken || (head_target != bus.actual_target));
  // A push alongside a mispredict belongs to the wrong path and is dropped.
  assign push = bus.fetch_valid && (!full || pop) && !mispredict;
  assign desync_next = bus.resolve_valid && (empty || (head_pc != bus.resolve_pc));

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]     <= bus.fetch_pc;
      taken_mem[wr_ptr_reg]  <= bus.pred_taken;
      target_mem[wr_ptr_reg] <= bus.pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (mispredict) begin
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push && !pop)      count_reg <= count_reg + CNT_ONE;
      else if (pop && !push) count_reg <= count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_en_reg        <= 1'b0;
      update_pc_reg        <= '0;
      update_target_reg    <= '0;
      redirect_reg         <= 1'b0;
      redirect_pc_reg      <= '0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
      desync_reg           <= 1'b0;
    end else begin
      update_en_reg <= need_update;
      redirect_reg  <= mispredict;
      if (need_update) begin
        update_pc_reg     <= bus.resolve_pc;
        update_target_reg <= bus.actual_target;
      end
      if (mispredict)
        redirect_pc_reg <= bus.actual_taken ? bus.actual_target : bus.resolve_pc + 32'd4;
      if (pop && (branch_count_reg != '1))
        branch_count_reg <= branch_count_reg + STAT_ONE;
      if (mispredict && (mispredict_count_reg != '1))
        mispredict_count_reg <= mispredict_count_reg + STAT_ONE;
      if (desync_next)
        desync_reg <= 1'b1;
    end
  end

  assign bus.fetch_ready      = !full;
  assign bus.update_en        = update_en_reg;
  assign bus.update_pc        = update_pc_reg;
  assign bus.update_target    = update_target_reg;
  assign bus.redirect         = redirect_reg;
  assign bus.redirect_pc      = redirect_pc_reg;
  assign bus.branch_count     = branch_count_reg;
  assign bus.mispredict_count = mispredict_count_reg;
  assign bus.desync_err       = desync_reg;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed vector table, corner-case sequences and random
// traffic compared against a queue-based prediction model.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(16)) bus ();
  branch_resolve_unit_if #(.CNT_W(2))  bus2 ();

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        pt;
    logic [31:0] ptg;
    logic        rv;
    logic [31:0] rpc;
    logic        at;
    logic [31:0] atg;
    logic        e_upd;
    logic [31:0] e_upc;
    logic [31:0] e_utg;
    logic        e_red;
    logic [31:0] e_rpc;
  } vec_t;

  int tests = 0;
  int fails = 0;

  ent_t        q[$];
  int          m_bc, m_mc;
  logic        m_desync;
  logic [31:0] m_upc, m_utg, m_rpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.fetch_valid = 0; bus.fetch_pc = 0; bus.pred_taken = 0; bus.pred_target = 0;
    bus.resolve_valid = 0; bus.resolve_pc = 0; bus.actual_taken = 0; bus.actual_target = 0;
  endtask

  task automatic model_clear();
    q.delete();
    m_bc = 0; m_mc = 0; m_desync = 0;
    m_upc = 0; m_utg = 0; m_rpc = 0;
  endtask

  // Enters and leaves at a falling edge; pulses rst across one rising edge.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_clear();
    @(posedge clk); #1;
    chk("rst_update_en", bus.update_en, 0);
    chk("rst_redirect", bus.redirect, 0);
    chk("rst_branch_count", bus.branch_count, 0);
    chk("rst_desync", bus.desync_err, 0);
    chk("rst_fetch_ready", bus.fetch_ready, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle of traffic; the model applies the queue/resolve rules directly.
  task automatic step(input logic fv, input logic [31:0] fpc, input logic pt, input logic [31:0] ptg,
                      input logic rv, input logic [31:0] rpc, input logic at, input logic [31:0] atg);
    ent_t h;
    logic mis, upd;
    bus.fetch_valid = fv; bus.fetch_pc = fpc; bus.pred_taken = pt; bus.pred_target = ptg;
    bus.resolve_valid = rv; bus.resolve_pc = rpc; bus.actual_taken = at; bus.actual_target = atg;
    #1;
    chk("fetch_ready", bus.fetch_ready, (q.size() < DEPTH) ? 1 : 0);
    mis = 0; upd = 0;
    if (rv) begin
      if (q.size() == 0) begin
        m_desync = 1;
      end else begin
        h = q.pop_front();
        if (h.pc != rpc) m_desync = 1;
        if (m_bc < 65535) m_bc++;
        if (at) mis = !h.taken || (h.target != atg);
        else    mis = h.taken;
        upd = at && (!h.taken || h.target != atg);
        if (mis) begin
          if (m_mc < 65535) m_mc++;
          q.delete();
          m_rpc = at ? atg : rpc + 32'd4;
        end
        if (upd) begin
          m_upc = rpc;
          m_utg = atg;
        end
      end
    end
    if (fv && !mis && q.size() < DEPTH) q.push_back('{fpc, pt, ptg});
    @(posedge clk); #1;
    chk("update_en", bus.update_en, upd);
    chk("update_pc", bus.update_pc, m_upc);
    chk("update_target", bus.update_target, m_utg);
    chk("redirect", bus.redirect, mis);
    chk("redirect_pc", bus.redirect_pc, m_rpc);
    chk("branch_count", bus.branch_count, m_bc);
    chk("mispredict_count", bus.mispredict_count, m_mc);
    chk("desync_err", bus.desync_err, m_desync);
    $display("[TB] fv=%0d fpc=%08h rv=%0d rpc=%08h at=%0d atg=%08h -> upd=%0d red=%0d rpc=%08h occ=%0d",
             fv, fpc, rv, rpc, at, atg, bus.update_en, bus.redirect, bus.redirect_pc, q.size());
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    logic [31:0] tgts[2];
    logic [31:0] pc_ctr;
    logic        fv, pt, rv, at;
    logic [31:0] rpc;

    vecs[0] = '{1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h0};
    vecs[1] = '{0, 32'h0,   0, 32'h0,   1, 32'h100, 1, 32'h200, 1, 32'h100, 32'h200, 1, 32'h200};
    vecs[2] = '{1, 32'h104, 1, 32'h300, 0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h200};
    vecs[3] = '{0, 32'h0,   0, 32'h0,   1, 32'h104, 0, 32'h0,   0, 32'h100, 32'h200, 1, 32'h108};
    vecs[4] = '{1, 32'h40,  1, 32'h80,  0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h108};
    vecs[5] = '{0, 32'h0,   0, 32'h0,   1, 32'h40,  1, 32'h80,  0, 32'h100, 32'h200, 0, 32'h108};
    vecs[6] = '{1, 32'h50,  1, 32'h80,  0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h108};
    vecs[7] = '{0, 32'h0,   0, 32'h0,   1, 32'h50,  1, 32'h90,  1, 32'h50,  32'h90,  1, 32'h90};

    clear_inputs();
    bus2.fetch_valid = 0; bus2.fetch_pc = 0; bus2.pred_taken = 0; bus2.pred_target = 0;
    bus2.resolve_valid = 0; bus2.resolve_pc = 0; bus2.actual_taken = 0; bus2.actual_target = 0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].fv, vecs[i].fpc, vecs[i].pt, vecs[i].ptg,
           vecs[i].rv, vecs[i].rpc, vecs[i].at, vecs[i].atg);
      chk("tbl_update_en", bus.update_en, vecs[i].e_upd);
      chk("tbl_update_pc", bus.update_pc, vecs[i].e_upc);
      chk("tbl_update_target", bus.update_target, vecs[i].e_utg);
      chk("tbl_redirect", bus.redirect, vecs[i].e_red);
      chk("tbl_redirect_pc", bus.redirect_pc, vecs[i].e_rpc);
    end
    chk("tbl_branch_count", bus.branch_count, 4);
    chk("tbl_mispredict_count", bus.mispredict_count, 3);

    // Fill, drop when full, push+pop while full, drain across the wrap.
    for (int i = 0; i < 4; i++) step(1, 32'h200 + 4 * i, i[0], 32'h900 + i, 0, 0, 0, 0);
    chk("full_fetch_ready", bus.fetch_ready, 0);
    step(1, 32'h210, 0, 0, 0, 0, 0, 0);
    step(1, 32'h214, 1, 32'h914, 1, 32'h200, 0, 0);
    chk("full_swap_fetch_ready", bus.fetch_ready, 0);
    step(0, 0, 0, 0, 1, 32'h204, 1, 32'h901);
    step(0, 0, 0, 0, 1, 32'h208, 0, 0);
    step(0, 0, 0, 0, 1, 32'h20c, 1, 32'h903);
    step(0, 0, 0, 0, 1, 32'h214, 1, 32'h914);
    chk("drain_desync", bus.desync_err, 0);
    chk("drain_redirect", bus.redirect, 0);

    // Mispredict flush discards a same-cycle push and the queued entries.
    step(1, 32'h300, 0, 0, 0, 0, 0, 0);
    step(1, 32'h304, 0, 0, 0, 0, 0, 0);
    step(1, 32'h500, 0, 0, 1, 32'h300, 1, 32'h400);
    step(0, 0, 0, 0, 1, 32'h304, 0, 0);
    chk("flush_desync", bus.desync_err, 1);
    chk("flush_no_update", bus.update_en, 0);

    // Head pc mismatch.
    do_reset();
    step(1, 32'h14, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h10, 0, 0);
    chk("pc_mismatch_desync", bus.desync_err, 1);

    // Reset asserted together with a mispredicting resolve.
    do_reset();
    step(1, 32'h100, 0, 0, 0, 0, 0, 0);
    bus.resolve_valid = 1; bus.resolve_pc = 32'h100; bus.actual_taken = 1; bus.actual_target = 32'h200;
    rst = 1'b1;
    #1;
    chk("rst_mid_branch_count", bus.branch_count, 0);
    chk("rst_mid_fetch_ready", bus.fetch_ready, 1);
    @(posedge clk); #1;
    chk("rst_mid_update_en", bus.update_en, 0);
    chk("rst_mid_redirect", bus.redirect, 0);
    chk("rst_mid_redirect_pc", bus.redirect_pc, 0);
    chk("rst_mid_mispredict_count", bus.mispredict_count, 0);
    @(negedge clk);
    do_reset();

    // Saturation on the narrow-counter instance.
    for (int i = 0; i < 5; i++) begin
      bus2.fetch_valid = 1; bus2.fetch_pc = 32'h600 + 4 * i; bus2.pred_taken = 0;
      @(negedge clk);
      bus2.fetch_valid = 0;
      bus2.resolve_valid = 1; bus2.resolve_pc = 32'h600 + 4 * i;
      bus2.actual_taken = 1; bus2.actual_target = 32'h700;
      @(negedge clk);
      bus2.resolve_valid = 0;
      $display("[TB] sat round %0d: mispredict_count=%0d branch_count=%0d",
               i, bus2.mispredict_count, bus2.branch_count);
    end
    chk("sat_mispredict_count", bus2.mispredict_count, 3);
    chk("sat_branch_count", bus2.branch_count, 3);
    chk("sat_desync", bus2.desync_err, 0);

    // Random traffic.
    tgts[0] = 32'h1000; tgts[1] = 32'h2000;
    pc_ctr = 32'h8000;
    for (int b = 0; b < 3; b++) begin
      do_reset();
      for (int i = 0; i < 100; i++) begin
        fv = 1'($urandom_range(0, 1));
        pt = 1'($urandom_range(0, 1));
        rv = ($urandom_range(0, 2) != 0);
        at = 1'($urandom_range(0, 1));
        if (q.size() > 0 && $urandom_range(0, 19) != 0) rpc = q[0].pc;
        else rpc = $urandom;
        step(fv, pc_ctr, pt, tgts[$urandom_range(0, 1)], rv, rpc, at, tgts[$urandom_range(0, 1)]);
        pc_ctr = pc_ctr + 32'd4;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
